digital_tube_bin2bcd: RTL and testbench

DIGITAL_TUBE_BIN2BCD -- requirements
Module: digital_tube_bin2bcd

---
 rtl/digital_tube_pkg.sv | 25 ++
 rtl/digital_tube_bcd_adj.sv | 14 +
 rtl/digital_tube_bin2bcd.sv | 143 ++++++++++++++
 tb/tb_digital_tube_bin2bcd.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/digital_tube_pkg.sv
// Shared types and constants for the digital-tube binary-to-BCD converter.
package digital_tube_pkg;

  localparam int unsigned BIN_W_DEF  = 20;
  localparam int unsigned DIGITS_DEF = 6;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  // Largest value representable with the given number of decimal digits.
  function automatic longint unsigned bcd_max(input int unsigned digits);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam longint unsigned BCD_MAX = bcd_max(DIGITS_DEF);

endpackage

// File: rtl/digital_tube_bcd_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
module digital_tube_bcd_adj (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = nibble;
    if (nibble >= 4'd5) begin
      adjusted = nibble + 4'd3;
    end
  end

endmodule

// File: rtl/digital_tube_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter with saturation and an
// optional leading-zero blank mask (enabled by DIGITAL_TUBE_LZ_BLANK_EN).
module digital_tube_bin2bcd
  import digital_tube_pkg::*;
#(
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [BIN_W-1:0]      bin_value,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   display_num,
  output logic                  display_enable,
  output logic                  out_valid,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int unsigned AccW = 4 * DIGITS + 4;
  localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam longint unsigned BcdMax = bcd_max(DIGITS);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [BIN_W-1:0]  shift_q;
  logic [AccW-1:0]   bcd_q;
  logic [AccW-1:0]   bcd_adj;
  logic              ovf_cap_q;
  logic              ready_en_q;
  logic              accept;
  logic              conv_last;

  logic [4*DIGITS-1:0] disp_q, disp_next;
  logic                ovf_q, ovf_next;
  logic                valid_q;
  logic                enable_q;

  genvar g;
  generate
    for (g = 0; g < DIGITS + 1; g++) begin : g_adj
      digital_tube_bcd_adj u_adj (
        .nibble   (bcd_q[4*g+:4]),
        .adjusted (bcd_adj[4*g+:4])
      );
    end
  endgenerate

  assign accept    = in_valid && in_ready;
  assign conv_last = (cnt_q == CntW'(BIN_W - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept)    state_d = StConv;
      StConv: if (conv_last) state_d = StDone;
      StDone:                state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  // The carry nibble catches overflow even if the accept-time compare were bypassed.
  always_comb begin
    ovf_next  = ovf_cap_q || (bcd_q[AccW-1:AccW-4] != 4'd0);
    disp_next = ovf_next ? {DIGITS{4'h9}} : bcd_q[4*DIGITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ready_en_q <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      ovf_cap_q  <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      valid_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shift_q   <= bin_value;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_cap_q <= (64'(bin_value) > BcdMax);
          end
        end
        StConv: begin
          bcd_q     <= {bcd_adj[AccW-2:0], shift_q[BIN_W-1]};
          shift_q   <= {shift_q[BIN_W-2:0], 1'b0};
          cnt_q     <= cnt_q + 1'b1;
          ovf_cap_q <= ovf_cap_q | bcd_adj[AccW-1];
        end
        StDone: begin
          disp_q   <= disp_next;
          ovf_q    <= ovf_next;
          valid_q  <= 1'b1;
          enable_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DIGITAL_TUBE_LZ_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_next;

  always_comb begin
    logic seen_nz;
    seen_nz    = 1'b0;
    blank_next = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (disp_next[4*i+:4] != 4'd0) seen_nz = 1'b1;
      blank_next[i] = !seen_nz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if (state_q == StDone) begin
      blank_q <= blank_next;
    end
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = '0;
`endif

  assign in_ready       = ready_en_q && (state_q == StIdle);
  assign display_num    = disp_q;
  assign overflow       = ovf_q;
  assign out_valid      = valid_q;
  assign display_enable = enable_q;

endmodule

// File: tb/tb_digital_tube_bin2bcd.sv
// Directed, table-driven bench for digital_tube_bin2bcd at default parameters.
module tb_digital_tube_bin2bcd;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] bin_value;
  logic        in_ready;
  logic [23:0] display_num;
  logic        display_enable;
  logic        out_valid;
  logic        overflow;
  logic [5:0]  blank_mask;

  int n_total  = 0;
  int n_passed = 0;

  digital_tube_bin2bcd dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .bin_value      (bin_value),
    .in_ready       (in_ready),
    .display_num    (display_num),
    .display_enable (display_enable),
    .out_valid      (out_valid),
    .overflow       (overflow),
    .blank_mask     (blank_mask)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    logic [19:0] bin;
    logic [23:0] disp;
    logic        ovf;
    logic [5:0]  blank;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_passed++;
    end
  endtask

  function automatic logic [5:0] exp_blank(input logic [5:0] b);
`ifdef DIGITAL_TUBE_LZ_BLANK_EN
    return b;
`else
    return 6'd0 & b;
`endif
  endfunction

  // Call at a negedge; returns #1 after the accepting posedge.
  task automatic accept(input logic [19:0] v, input bit hold);
    int waited = 0;
    in_valid  = 1'b1;
    bin_value = v;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  // Observes the 22 negedges following accept edge N.
  task automatic monitor_conv(input string tag, input logic [23:0] ed, input logic eo,
                              input logic [5:0] eb);
    int bad_ready = 0;
    int pulses    = 0;
    int pulse_k   = -1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (k < 21 && in_ready) bad_ready++;
      if (out_valid) begin
        pulses++;
        pulse_k = k;
      end
      if (k == 21) begin
        check({tag, " display_num"}, 64'(display_num), 64'(ed));
        check({tag, " overflow"}, 64'(overflow), 64'(eo));
        check({tag, " blank_mask"}, 64'(blank_mask), 64'(exp_blank(eb)));
        check({tag, " display_enable"}, 64'(display_enable), 64'd1);
        check({tag, " ready_after_done"}, 64'(in_ready), 64'd1);
      end
    end
    check({tag, " ready_low_cycles"}, 64'(bad_ready), 64'd0);
    check({tag, " valid_pulse_k"}, 64'(pulse_k), 64'd21);
    check({tag, " valid_pulse_count"}, 64'(pulses), 64'd1);
  endtask

  task automatic hold_check(input string tag, input logic [23:0] ed);
    @(negedge clk);
    check({tag, " valid_dropped"}, 64'(out_valid), 64'd0);
    check({tag, " display_held"}, 64'(display_num), 64'(ed));
  endtask

  initial begin
    vecs[0] = '{bin: 20'd0,       disp: 24'h000000, ovf: 1'b0, blank: 6'b111110};
    vecs[1] = '{bin: 20'd123456,  disp: 24'h123456, ovf: 1'b0, blank: 6'b000000};
    vecs[2] = '{bin: 20'd1048575, disp: 24'h999999, ovf: 1'b1, blank: 6'b000000};
    vecs[3] = '{bin: 20'd7,       disp: 24'h000007, ovf: 1'b0, blank: 6'b111110};
    vecs[4] = '{bin: 20'd100000,  disp: 24'h100000, ovf: 1'b0, blank: 6'b000000};
    vecs[5] = '{bin: 20'd305,     disp: 24'h000305, ovf: 1'b0, blank: 6'b111000};
    vecs[6] = '{bin: 20'd90009,   disp: 24'h090009, ovf: 1'b0, blank: 6'b100000};
    vecs[7] = '{bin: 20'd999999,  disp: 24'h999999, ovf: 1'b0, blank: 6'b000000};
    vecs[8] = '{bin: 20'd1000000, disp: 24'h999999, ovf: 1'b1, blank: 6'b000000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bin_value = '0;
    #55;
    check("rst display_num", 64'(display_num), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst display_enable", 64'(display_enable), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst blank_mask", 64'(blank_mask), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("release in_ready_after_edge", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Table of single conversions with idle gaps.
    for (int i = 0; i < 7; i++) begin
      accept(vecs[i].bin, 1'b0);
      monitor_conv($sformatf("vec%0d", i), vecs[i].disp, vecs[i].ovf, vecs[i].blank);
      hold_check($sformatf("vec%0d", i), vecs[i].disp);
    end

    // Back-to-back: 999999 then 1000000 with in_valid held high.
    accept(vecs[7].bin, 1'b1);
    bin_value = vecs[8].bin;
    monitor_conv("b2b_first", vecs[7].disp, vecs[7].ovf, vecs[7].blank);
    @(posedge clk);
    #1;
    check("b2b accept_at_n22", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    monitor_conv("b2b_second", vecs[8].disp, vecs[8].ovf, vecs[8].blank);
    hold_check("b2b_second", vecs[8].disp);

    // Reset during CONV cycle 10 of 654321.
    accept(20'd654321, 1'b0);
    repeat (10) @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check("midrst display_num", 64'(display_num), 64'd0);
    check("midrst overflow", 64'(overflow), 64'd0);
    check("midrst display_enable", 64'(display_enable), 64'd0);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int stray = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (out_valid || display_enable) stray++;
      end
      check("midrst no_stray_output", 64'(stray), 64'd0);
    end
    accept(20'd42, 1'b0);
    monitor_conv("post_rst_42", 24'h000042, 1'b0, 6'b111100);
    hold_check("post_rst_42", 24'h000042);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

  // Overall time guard so the bench cannot hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", n_passed, n_total);
    $fatal(1);
  end

endmodule
